// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
//   Shared definitions for the iterative multiplier:
//     state_t    - FSM state encoding (IDLE / CALC / DONE)
//     BPC_MAX    - widest legal digit retired per iteration
//     calc_n()   - number of iterations N = WIDTH / BITS_PER_CYCLE
//     bpc_legal()- legality check for the BITS_PER_CYCLE / WIDTH pair
// -----------------------------------------------------------------------------
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BPC_MAX = 4;

    function automatic int calc_n(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic bit bpc_legal(input int width, input int bpc);
        return ((bpc == 1) || (bpc == 2) || (bpc == BPC_MAX)) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/mul_pp_step.sv
// -----------------------------------------------------------------------------
// mul_pp_step
//   Combinational partial-product generator plus adder. Adds the product of a
//   BITS_PER_CYCLE-bit multiplier digit and the (already shifted) multiplicand
//   to the running accumulator.
//   Ports:
//     digit_i    in  BITS_PER_CYCLE  low multiplier bits for this iteration
//     mcand_i    in  2*WIDTH         multiplicand shifted by BPC*counter
//     acc_i      in  2*WIDTH         current accumulator
//     acc_o      out 2*WIDTH         accumulator after this iteration
// -----------------------------------------------------------------------------
module mul_pp_step
    import mul_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [BITS_PER_CYCLE-1:0] digit_i,
    input  logic [2*WIDTH-1:0]        mcand_i,
    input  logic [2*WIDTH-1:0]        acc_i,
    output logic [2*WIDTH-1:0]        acc_o
);

    logic [2*WIDTH-1:0] pp;

    // Shift-and-add over the digit bits; no hard multiplier is needed for a
    // digit of at most four bits.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so the loop sees the
        // partial sum built by the previous iteration, and pp gets a default
        // first so no latch is inferred.
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (digit_i[i]) begin
                pp = pp + (mcand_i << i);
            end
        end
    end

    assign acc_o = acc_i + pp;

endmodule

// File: rtl/mul_seq_param.sv
// -----------------------------------------------------------------------------
// mul_seq_param
//   Iterative multiplier for mult/multu. Retires BITS_PER_CYCLE multiplier bits
//   per clock; operands and sign are captured at acceptance. Result is ready
//   N+1 cycles after acceptance (N = WIDTH/BITS_PER_CYCLE) and held while
//   start_i stays high.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     signed_i   1 = two's-complement operands (sampled at acceptance)
//     op_a_i     multiplicand (sampled at acceptance)
//     op_b_i     multiplier   (sampled at acceptance)
//     start_i    level-held request
//     annul_i    abort, overrides start and completion
//     busy_o     high in CALC and DONE
//     ready_o    result valid
//     result_o   2*WIDTH product, zero whenever ready_o is low
// -----------------------------------------------------------------------------
module mul_seq_param
    import mul_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     op_a_i,
    input  logic [WIDTH-1:0]     op_b_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int PW = 2 * WIDTH;
    localparam int N  = calc_n(WIDTH, BITS_PER_CYCLE);
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N);
    localparam logic [PW-1:0] PROD_ONE = PW'(1);

    if (!bpc_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_bpc
        $error("mul_seq_param: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
    end

    state_t            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     result_q, result_d;
    logic              ready_q, ready_d;

    logic              accept;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [PW-1:0]     acc_next;

    assign accept = (state_q == IDLE) && start_i && !annul_i;

    // Magnitudes stay WIDTH bits: -2^(WIDTH-1) negates to itself, which read
    // unsigned is exactly 2^(WIDTH-1).
    assign a_mag = (signed_i && op_a_i[WIDTH-1]) ? (~op_a_i + WIDTH'(1)) : op_a_i;
    assign b_mag = (signed_i && op_b_i[WIDTH-1]) ? (~op_b_i + WIDTH'(1)) : op_b_i;

    mul_pp_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_pp_step (
        .digit_i (mplier_q[BITS_PER_CYCLE-1:0]),
        .mcand_i (mcand_q),
        .acc_i   (acc_q),
        .acc_o   (acc_next)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: every register, datapath included, is reset so a flush by rst
        // leaves no stale operand or partial product behind.
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state logic. annul_i wins over start_i and over completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: begin
                if (annul_i)                state_d = IDLE;
                else if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: if (annul_i || !start_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values. The counter reaching N is checked one cycle after
    // the last iteration, which is where the extra latency cycle comes from.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        ready_d  = ready_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mcand_d  = PW'(a_mag);
                    mplier_d = b_mag;
                    neg_d    = signed_i & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            CALC: begin
                if (annul_i) begin
                    acc_d    = '0;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = neg_q ? (~acc_q + PROD_ONE) : acc_q;
                    ready_d  = 1'b1;
                end else begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << BITS_PER_CYCLE;
                    mplier_d = mplier_q >> BITS_PER_CYCLE;
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                if (annul_i || !start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        busy_o   = (state_q != IDLE);
        ready_o  = ready_q;
        result_o = result_q;
    end

endmodule
